alu_pipe: RTL and testbench

//   Parametrised, two-stage pipelined successor to the 4-bit combinational ALU.

---
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_pipe.sv | 115 +++++++++++
 tb/tb_alu_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: operand beat in, result beat plus flags and count out.
// "master" is the operand source / result consumer side, and "slave" is the ALU pipeline.
interface alu_pipe_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   alu_out;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic [CNT_W-1:0] res_count;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_out, flag_z, flag_n, flag_v, res_count
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, alu_out, flag_z, flag_n, flag_v, res_count
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, registered flags and a wrapping hand-off count.
// Stage 1 captures operands, and stage 2 computes and holds the result until the consumer takes it.
module alu_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    alu_pipe_if.slave  bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_sel;

    logic             r_s2_valid;
    logic [WIDTH:0]   r_s2_out;
    logic             r_s2_z;
    logic             r_s2_n;
    logic             r_s2_v;
    logic [CNT_W-1:0] r_count;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_handoff;
    logic [WIDTH:0]   w_res;
    logic             w_v;

    // Stage 2 frees up when it is empty or draining, and stage 1 frees up when stage 2 can take its beat.
    assign w_s2_adv  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_handoff = r_s2_valid && bus.out_ready;

    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        unique case (r_s1_sel)
            OP_ADD: begin
                w_res = {1'b0, r_s1_a} + {1'b0, r_s1_b};
                w_v   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = {1'b0, r_s1_a} - {1'b0, r_s1_b};
                w_v   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            OP_AND:  w_res = {1'b0, r_s1_a & r_s1_b};
            OP_OR:   w_res = {1'b0, r_s1_a | r_s1_b};
            OP_XOR:  w_res = {1'b0, r_s1_a ^ r_s1_b};
            OP_NOT:  w_res = {1'b0, ~r_s1_a};
            OP_SHL:  w_res = {r_s1_a, 1'b0};
            default: w_res = {2'b00, r_s1_a[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_sel   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_a   <= bus.a;
                r_s1_b   <= bus.b;
                r_s1_sel <= bus.alu_sel;
            end
        end
    end

    // Result and flags only move when the consumer is not stalling, so they hold while out_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_out   <= '0;
            r_s2_z     <= 1'b0;
            r_s2_n     <= 1'b0;
            r_s2_v     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_out <= w_res;
                r_s2_z   <= (w_res[WIDTH-1:0] == '0);
                r_s2_n   <= w_res[WIDTH-1];
                r_s2_v   <= w_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_handoff) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.alu_out   = r_s2_out;
    assign bus.flag_z    = r_s2_z;
    assign bus.flag_n    = r_s2_n;
    assign bus.flag_v    = r_s2_v;
    assign bus.res_count = r_count;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=4, CNT_W=3): the drivers queue expected results, and a monitor checks hand-offs.
`timescale 1ns/1ps
module tb_alu_pipe;
    typedef struct {
        logic [4:0] out;
        logic       z;
        logic       n;
        logic       v;
        int         acc_edge;
        bit         lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    logic [2:0] exp_cnt;
    exp_t sb[$];
    bit   held_v;
    logic [7:0] held;
    int   ready_low_seen;
    bit   rnd_done;

    alu_pipe_if #(.WIDTH(4), .CNT_W(3)) bus ();

    alu_pipe #(.WIDTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input logic [2:0] ms);
        exp_t e;
        logic [4:0] r;
        logic v;
        v = 1'b0;
        case (ms)
            3'd0: begin r = {1'b0, ma} + {1'b0, mb}; v = (ma[3] == mb[3]) && (r[3] != ma[3]); end
            3'd1: begin r = {1'b0, ma} - {1'b0, mb}; v = (ma[3] != mb[3]) && (r[3] != ma[3]); end
            3'd2: r = {1'b0, ma & mb};
            3'd3: r = {1'b0, ma | mb};
            3'd4: r = {1'b0, ma ^ mb};
            3'd5: r = {1'b0, ~ma};
            3'd6: r = {ma, 1'b0};
            default: r = {2'b00, ma[3:1]};
        endcase
        e.out = r;
        e.z = (r[3:0] == 4'd0);
        e.n = r[3];
        e.v = v;
        e.acc_edge = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [4:0] o, input logic z, input logic n, input logic v, input bit lat);
        exp_t e;
        e.out = o; e.z = z; e.n = n; e.v = v; e.acc_edge = 0; e.lat = lat;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb_b, input logic [2:0] ts, input exp_t e);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = ta;
        bus.b = tb_b;
        bus.alu_sel = ts;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc_edge = cyc + 1;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
        chk("drain_queue_empty", sb.size(), 32'd0);
        #1;
    endtask

    // Monitor: pops on every hand-off, and checks that a stalled result holds still.
    initial begin
        exp_t e;
        exp_cnt = '0;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_cnt = '0;
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                    chk("hold_data", {24'd0, bus.alu_out, bus.flag_z, bus.flag_n, bus.flag_v}, {24'd0, held});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", {27'd0, bus.alu_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("alu_out", {27'd0, bus.alu_out}, {27'd0, e.out});
                        chk("flags_znv", {29'd0, bus.flag_z, bus.flag_n, bus.flag_v}, {29'd0, e.z, e.n, e.v});
                        if (e.lat) chk("latency", cyc + 1 - e.acc_edge, 32'd2);
                    end
                    chk("res_count", {29'd0, bus.res_count}, {29'd0, exp_cnt});
                    exp_cnt = exp_cnt + 3'd1;
                    held_v = 1'b0;
                end else if (bus.out_valid) begin
                    held_v = 1'b1;
                    held = {bus.alu_out, bus.flag_z, bus.flag_n, bus.flag_v};
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [4:0] t1_out [8];
        logic [2:0] t1_znv [8];
        checks = 0;
        failures = 0;
        ready_low_seen = 0;
        rnd_done = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.alu_sel = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_alu_out", {27'd0, bus.alu_out}, 32'd0);
        chk("rst_flags", {29'd0, bus.flag_z, bus.flag_n, bus.flag_v}, 32'd0);
        chk("rst_res_count", {29'd0, bus.res_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

        // Test 1: a=5, b=3, every opcode back-to-back
        t1_out = '{5'b01000, 5'b00010, 5'b00001, 5'b00111, 5'b00110, 5'b01010, 5'b01010, 5'b00010};
        t1_znv = '{3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000};
        for (int i = 0; i < 8; i++)
            send(4'd5, 4'd3, 3'(i), mk(t1_out[i], t1_znv[i][2], t1_znv[i][1], t1_znv[i][0], 1'b1));
        drain();

        // Test 2: borrow and zero cases
        send(4'd3, 4'd5, 3'd1, mk(5'b11110, 1'b0, 1'b1, 1'b0, 1'b1));
        send(4'hF, 4'd1, 3'd0, mk(5'b10000, 1'b1, 1'b0, 1'b0, 1'b1));
        send(4'd7, 4'd1, 3'd0, mk(5'b01000, 1'b0, 1'b1, 1'b1, 1'b1));
        send(4'd8, 4'd1, 3'd1, mk(5'b00111, 1'b0, 1'b0, 1'b1, 1'b1));
        drain();

        // Test 3: six beats with the consumer stalled for cycles 2-5
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(4'(i), 4'd1, 3'd0, mk(5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0));
            end
            begin
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (!bus.in_ready) ready_low_seen = ready_low_seen + 1;
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("in_ready_dropped_on_stall", {31'd0, ready_low_seen > 0}, 32'd1);

        // Test 5: reset with two beats in flight
        send(4'd1, 4'd2, 3'd3, mk(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0));
        send(4'd4, 4'd4, 3'd4, mk(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_res_count", {29'd0, bus.res_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("in_ready_after_midrst", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale_beat", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Test 4: nine hand-offs on a 3-bit counter wrap to 1
        for (int i = 0; i < 9; i++)
            send(4'hF, 4'(i), 3'd2, mk({1'b0, 4'(i)}, (i == 0), (i >= 8), 1'b0, 1'b1));
        drain();
        chk("res_count_wrapped", {29'd0, bus.res_count}, 32'd1);

        // Test 6: random operands with random valid gaps and consumer back-pressure
        fork
            begin
                logic [3:0] ra, rb;
                logic [2:0] rs;
                for (int i = 0; i < 40; i++) begin
                    ra = 4'($urandom_range(0, 15));
                    rb = 4'($urandom_range(0, 15));
                    rs = 3'($urandom_range(0, 7));
                    send(ra, rb, rs, model(ra, rb, rs));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
